// File: rtl/rotary_level_ctrl.sv
// Quadrature rotary-encoder front end: synchroniser, per-channel debounce, detent FSM
// and a bounded level register. Define ROTARY_ACCEL_EN to enable fast-spin acceleration.
module rotary_level_ctrl #(
    parameter int WIDTH           = 4,
    parameter int MIN_LEVEL       = 9,
    parameter int MAX_LEVEL       = 14,
    parameter int RESET_LEVEL     = 13,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WRAP            = 0
`ifdef ROTARY_ACCEL_EN
    ,
    parameter int ACCEL_WINDOW    = 1_000_000,
    parameter int ACCEL_STEP      = 2
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rotary_inc_a,
    input  logic             rotary_inc_b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_level,
    output logic [WIDTH-1:0] level,
    output logic             inc_pulse,
    output logic             dec_pulse,
    output logic             at_min,
    output logic             at_max
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A,
        S_AB_A,
        S_BA,
        S_B,
        S_AB_B,
        S_AB
    } state_t;

    localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN_LEVEL);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_LEVEL);

    // Channel vectors are packed as {a, b}.
    logic [1:0] sync_1, sync_2, filt;
    state_t     state, state_next;
    logic       inc_evt, dec_evt;
    logic [WIDTH:0] step, lvl_x, load_x, lvl_nx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {rotary_inc_a, rotary_inc_b};
            sync_2 <= sync_1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt = sync_2;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            for (genvar ch = 0; ch < 2; ch++) begin : g_ch
                logic [CW-1:0] cnt;
                logic          f;
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cnt <= '0;
                        f   <= 1'b0;
                    end else if (sync_2[ch] == f) begin
                        cnt <= '0;
                    end else if (int'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
                        f   <= sync_2[ch];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                assign filt[ch] = f;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        inc_evt    = 1'b0;
        dec_evt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (filt[1])      state_next = S_A;
                else if (filt[0]) state_next = S_B;
            end
            S_A: begin
                case (filt)
                    2'b00:   state_next = S_IDLE;
                    2'b10:   state_next = S_A;
                    default: state_next = S_AB_A;
                endcase
            end
            S_AB_A: begin
                case (filt)
                    2'b10:   state_next = S_A;
                    2'b01:   state_next = S_BA;
                    2'b11:   state_next = S_AB_A;
                    default: begin state_next = S_IDLE; dec_evt = 1'b1; end
                endcase
            end
            S_BA: begin
                if (filt[1])            state_next = S_AB_A;
                else if (filt == 2'b00) begin state_next = S_IDLE; dec_evt = 1'b1; end
            end
            S_B: begin
                case (filt)
                    2'b00:   state_next = S_IDLE;
                    2'b01:   state_next = S_B;
                    default: state_next = S_AB_B;
                endcase
            end
            S_AB_B: begin
                case (filt)
                    2'b01:   state_next = S_B;
                    2'b10:   state_next = S_AB;
                    2'b11:   state_next = S_AB_B;
                    default: begin state_next = S_IDLE; inc_evt = 1'b1; end
                endcase
            end
            S_AB: begin
                if (filt[0])            state_next = S_AB_B;
                else if (filt == 2'b00) begin state_next = S_IDLE; inc_evt = 1'b1; end
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef ROTARY_ACCEL_EN
    localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(ACCEL_WINDOW);
    logic [GAP_W-1:0] gap;

    // Starts saturated so the first detent after reset is a single step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 gap <= GAP_SAT;
        else if (inc_evt | dec_evt) gap <= '0;
        else if (gap != GAP_SAT)   gap <= gap + 1'b1;
    end

    assign step = (int'(gap) < ACCEL_WINDOW) ? (WIDTH+1)'(ACCEL_STEP) : (WIDTH+1)'(1);
`else
    assign step = (WIDTH+1)'(1);
`endif

    // One extra bit keeps level +/- step from wrapping before the bound clamp.
    always_comb begin
        lvl_x  = {1'b0, level};
        load_x = {1'b0, load_level};
        lvl_nx = lvl_x;
        if (load) begin
            if (load_x < MIN_X)      lvl_nx = MIN_X;
            else if (load_x > MAX_X) lvl_nx = MAX_X;
            else                     lvl_nx = load_x;
        end else if (inc_evt) begin
            if (lvl_x == MAX_X)             lvl_nx = (WRAP != 0) ? MIN_X : MAX_X;
            else if (lvl_x + step > MAX_X)  lvl_nx = MAX_X;
            else                            lvl_nx = lvl_x + step;
        end else if (dec_evt) begin
            if (lvl_x == MIN_X)             lvl_nx = (WRAP != 0) ? MAX_X : MIN_X;
            else if (lvl_x < MIN_X + step)  lvl_nx = MIN_X;
            else                            lvl_nx = lvl_x - step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level     <= WIDTH'(RESET_LEVEL);
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            level     <= lvl_nx[WIDTH-1:0];
            inc_pulse <= inc_evt;
            dec_pulse <= dec_evt;
        end
    end

    assign at_min = (level == WIDTH'(MIN_LEVEL));
    assign at_max = (level == WIDTH'(MAX_LEVEL));

endmodule

// File: tb/tb_rotary_level_ctrl.sv
// Self-checking bench for rotary_level_ctrl: a saturating and a wrapping instance share stimulus
// and are compared against a detent-level model of the level rules.
module tb_rotary_level_ctrl;

    localparam int WIDTH = 4;
    localparam int MINL  = 9;
    localparam int MAXL  = 14;
    localparam int RSTL  = 13;
    localparam int DB    = 4;
`ifdef ROTARY_ACCEL_EN
    localparam int IDLE_GAP = 120;
`else
    localparam int IDLE_GAP = 4;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             a, b, load;
    logic [WIDTH-1:0] load_level;
    logic [WIDTH-1:0] level0, level1;
    logic             inc0, dec0, min0, max0;
    logic             inc1, dec1, min1, max1;

    int checks = 0, failures = 0;
    int inc_cnt0 = 0, dec_cnt0 = 0, inc_cnt1 = 0, dec_cnt1 = 0, both_cnt = 0;
    int m_lvl0, m_lvl1, m_inc = 0, m_dec = 0;

    always #5 clk = ~clk;

    rotary_level_ctrl #(
`ifdef ROTARY_ACCEL_EN
        .ACCEL_WINDOW(100), .ACCEL_STEP(2),
`endif
        .WIDTH(WIDTH), .MIN_LEVEL(MINL), .MAX_LEVEL(MAXL), .RESET_LEVEL(RSTL),
        .DEBOUNCE_CYCLES(DB), .WRAP(0)
    ) dut0 (
        .clk(clk), .reset(reset), .rotary_inc_a(a), .rotary_inc_b(b),
        .load(load), .load_level(load_level), .level(level0),
        .inc_pulse(inc0), .dec_pulse(dec0), .at_min(min0), .at_max(max0)
    );

    rotary_level_ctrl #(
`ifdef ROTARY_ACCEL_EN
        .ACCEL_WINDOW(100), .ACCEL_STEP(2),
`endif
        .WIDTH(WIDTH), .MIN_LEVEL(MINL), .MAX_LEVEL(MAXL), .RESET_LEVEL(RSTL),
        .DEBOUNCE_CYCLES(DB), .WRAP(1)
    ) dut1 (
        .clk(clk), .reset(reset), .rotary_inc_a(a), .rotary_inc_b(b),
        .load(load), .load_level(load_level), .level(level1),
        .inc_pulse(inc1), .dec_pulse(dec1), .at_min(min1), .at_max(max1)
    );

    // Pulse monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset === 1'b0) begin
            if (inc0 === 1'b1) inc_cnt0++;
            if (dec0 === 1'b1) dec_cnt0++;
            if (inc1 === 1'b1) inc_cnt1++;
            if (dec1 === 1'b1) dec_cnt1++;
            if ((inc0 === 1'b1 && dec0 === 1'b1) || (inc1 === 1'b1 && dec1 === 1'b1)) both_cnt++;
        end
    end

    function automatic int model_step(int lvl, bit up, bit wrap, int step);
        if (up) begin
            if (lvl == MAXL) return wrap ? MINL : MAXL;
            return (lvl + step > MAXL) ? MAXL : lvl + step;
        end
        if (lvl == MINL) return wrap ? MAXL : MINL;
        return (lvl - step < MINL) ? MINL : lvl - step;
    endfunction

    function automatic int model_clamp(int v);
        return (v < MINL) ? MINL : ((v > MAXL) ? MAXL : v);
    endfunction

    task automatic drive(bit va, bit vb, int n);
        a = va;
        b = vb;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a = 1'b0; b = 1'b0; load = 1'b0; load_level = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_lvl0 = RSTL;
        m_lvl1 = RSTL;
        drive(0, 0, 3);
    endtask

    // Full detent; cw means B leads. Model is updated with the expected outcome.
    task automatic detent(bit cw, int h);
        if (cw) begin drive(0, 1, h); drive(1, 1, h); drive(1, 0, h); end
        else    begin drive(1, 0, h); drive(1, 1, h); drive(0, 1, h); end
        drive(0, 0, DB + 6 + IDLE_GAP);
        m_lvl0 = model_step(m_lvl0, cw, 1'b0, 1);
        m_lvl1 = model_step(m_lvl1, cw, 1'b1, 1);
        if (cw) m_inc++; else m_dec++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a = 1'b0; b = 1'b0; load = 1'b0; load_level = '0;
        repeat (3) @(negedge clk);
        checks++; if (level0 !== 4'(RSTL)) begin failures++; $display("FAIL reset_level got=%0d want=%0d", level0, RSTL); end
        checks++; if (level1 !== 4'(RSTL)) begin failures++; $display("FAIL reset_level_wrap got=%0d want=%0d", level1, RSTL); end
        checks++; if ({min0, max0, inc0, dec0} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", {min0, max0, inc0, dec0}); end
        reset = 1'b0;
        m_lvl0 = RSTL;
        m_lvl1 = RSTL;
        drive(0, 0, 5);
        drive(1, 0, 10);
        drive(1, 1, 10);
        reset = 1'b1;
        a = 1'b0; b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 30);
        checks++; if (inc_cnt0 + dec_cnt0 + inc_cnt1 + dec_cnt1 !== 0) begin failures++; $display("FAIL reset_mid_pulses got=%0d want=0", inc_cnt0 + dec_cnt0 + inc_cnt1 + dec_cnt1); end
        checks++; if (level0 !== 4'(RSTL)) begin failures++; $display("FAIL reset_mid_level got=%0d want=%0d", level0, RSTL); end
    endtask

    task automatic test_cw_saturate();
        drive(0, 1, 10);
        drive(1, 1, 10);
        drive(1, 0, 10);
        a = 1'b0; b = 1'b0;
        repeat (DB + 2) @(negedge clk);
        checks++; if (level0 !== 4'd13 || inc0 !== 1'b0) begin failures++; $display("FAIL cw_early level=%0d inc=%b want 13/0", level0, inc0); end
        @(negedge clk);
        checks++; if (level0 !== 4'd14) begin failures++; $display("FAIL cw_latency_level got=%0d want=14", level0); end
        checks++; if (inc0 !== 1'b1 || inc1 !== 1'b1 || dec0 !== 1'b0) begin failures++; $display("FAIL cw_pulse got inc0=%b inc1=%b dec0=%b want 1/1/0", inc0, inc1, dec0); end
        checks++; if (max0 !== 1'b1) begin failures++; $display("FAIL cw_at_max got=%b want=1", max0); end
        @(negedge clk);
        checks++; if (inc0 !== 1'b0) begin failures++; $display("FAIL cw_pulse_width got=%b want=0", inc0); end
        drive(0, 0, IDLE_GAP);
        m_lvl0 = model_step(m_lvl0, 1'b1, 1'b0, 1);
        m_lvl1 = model_step(m_lvl1, 1'b1, 1'b1, 1);
        m_inc++;
        detent(1'b1, 10);
        checks++; if (level0 !== 4'd14) begin failures++; $display("FAIL cw_hold got=%0d want=14", level0); end
        checks++; if (level1 !== 4'd9 || min1 !== 1'b1) begin failures++; $display("FAIL cw_wrap got=%0d min=%b want 9/1", level1, min1); end
        checks++; if (inc_cnt0 !== m_inc) begin failures++; $display("FAIL cw_pulse_count got=%0d want=%0d", inc_cnt0, m_inc); end
    endtask

    task automatic test_ccw_bounds();
        int exp0[6] = '{12, 11, 10, 9, 9, 9};
        int exp1[6] = '{12, 11, 10, 9, 14, 13};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            detent(1'b0, 10);
            checks++; if (level0 !== 4'(exp0[i])) begin failures++; $display("FAIL ccw_sat_%0d got=%0d want=%0d", i, level0, exp0[i]); end
            checks++; if (level1 !== 4'(exp1[i])) begin failures++; $display("FAIL ccw_wrap_%0d got=%0d want=%0d", i, level1, exp1[i]); end
        end
        checks++; if (min0 !== 1'b1) begin failures++; $display("FAIL ccw_at_min got=%b want=1", min0); end
        checks++; if (dec_cnt0 !== m_dec || dec_cnt1 !== m_dec) begin failures++; $display("FAIL ccw_pulse_count got=%0d/%0d want=%0d", dec_cnt0, dec_cnt1, m_dec); end
    endtask

    task automatic test_debounce();
        drive(1, 0, DB - 1);
        drive(0, 0, DB + 10);
        checks++; if (level0 !== 4'(m_lvl0) || inc_cnt0 + dec_cnt0 !== m_inc + m_dec) begin failures++; $display("FAIL glitch_reject level=%0d pulses=%0d want %0d/%0d", level0, inc_cnt0 + dec_cnt0, m_lvl0, m_inc + m_dec); end
        // B held exactly DB cycles before A joins: only a B-first filtered path yields an inc.
        drive(0, 1, DB);
        drive(1, 1, 10);
        drive(1, 0, 10);
        drive(0, 0, DB + 6 + IDLE_GAP);
        m_lvl0 = model_step(m_lvl0, 1'b1, 1'b0, 1);
        m_lvl1 = model_step(m_lvl1, 1'b1, 1'b1, 1);
        m_inc++;
        checks++; if (inc_cnt0 !== m_inc || level0 !== 4'(m_lvl0)) begin failures++; $display("FAIL debounce_accept inc=%0d level=%0d want %0d/%0d", inc_cnt0, level0, m_inc, m_lvl0); end
    endtask

    task automatic test_partial_load();
        drive(0, 1, 10);
        drive(1, 1, 10);
        drive(0, 1, 10);
        drive(0, 0, DB + 6 + IDLE_GAP);
        checks++; if (level0 !== 4'(m_lvl0) || level1 !== 4'(m_lvl1) || inc_cnt0 + dec_cnt0 !== m_inc + m_dec) begin failures++; $display("FAIL partial level=%0d/%0d pulses=%0d want %0d/%0d/%0d", level0, level1, inc_cnt0 + dec_cnt0, m_lvl0, m_lvl1, m_inc + m_dec); end
        drive(1, 0, 10);
        drive(1, 1, 10);
        drive(0, 1, 10);
        a = 1'b0; b = 1'b0;
        repeat (DB + 2) @(negedge clk);
        load = 1'b1;
        load_level = 4'd15;
        @(negedge clk);
        checks++; if (level0 !== 4'd14 || level1 !== 4'd14) begin failures++; $display("FAIL load_clamp got=%0d/%0d want=14", level0, level1); end
        checks++; if (dec0 !== 1'b1 || dec1 !== 1'b1) begin failures++; $display("FAIL load_dec_pulse got=%b/%b want=1", dec0, dec1); end
        load = 1'b0;
        m_lvl0 = 14;
        m_lvl1 = 14;
        m_dec++;
        drive(0, 0, IDLE_GAP);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int kind = int'($urandom_range(0, 4));
            int h    = int'($urandom_range(DB + 1, DB + 8));
            case (kind)
                0: detent(1'b1, h);
                1: detent(1'b0, h);
                2: begin
                    if ($urandom_range(0, 1) == 1) begin drive(0, 1, h); drive(1, 1, h); drive(0, 1, h); end
                    else                           begin drive(1, 0, h); drive(1, 1, h); drive(1, 0, h); end
                    drive(0, 0, DB + 6);
                end
                3: begin
                    int g = int'($urandom_range(1, DB - 1));
                    if ($urandom_range(0, 1) == 1) drive(1, 0, g); else drive(0, 1, g);
                    drive(0, 0, DB + 6);
                end
                default: begin
                    int v = int'($urandom_range(0, 15));
                    load = 1'b1;
                    load_level = 4'(v);
                    @(negedge clk);
                    load = 1'b0;
                    m_lvl0 = model_clamp(v);
                    m_lvl1 = model_clamp(v);
                    drive(0, 0, 3);
                end
            endcase
            checks++; if (level0 !== 4'(m_lvl0)) begin failures++; $display("FAIL rand_%0d_k%0d level_sat got=%0d want=%0d", it, kind, level0, m_lvl0); end
            checks++; if (level1 !== 4'(m_lvl1)) begin failures++; $display("FAIL rand_%0d_k%0d level_wrap got=%0d want=%0d", it, kind, level1, m_lvl1); end
            checks++; if (inc_cnt0 !== m_inc || inc_cnt1 !== m_inc) begin failures++; $display("FAIL rand_%0d inc_count got=%0d/%0d want=%0d", it, inc_cnt0, inc_cnt1, m_inc); end
            checks++; if (dec_cnt0 !== m_dec || dec_cnt1 !== m_dec) begin failures++; $display("FAIL rand_%0d dec_count got=%0d/%0d want=%0d", it, dec_cnt0, dec_cnt1, m_dec); end
        end
    endtask

`ifdef ROTARY_ACCEL_EN
    task automatic test_accel();
        do_reset();
        load = 1'b1;
        load_level = 4'd9;
        @(negedge clk);
        load = 1'b0;
        drive(0, 0, 150);
        drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 20);
        checks++; if (level0 !== 4'd10) begin failures++; $display("FAIL accel_first got=%0d want=10", level0); end
        drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 20);
        checks++; if (level0 !== 4'd12 || level1 !== 4'd12) begin failures++; $display("FAIL accel_second got=%0d/%0d want=12", level0, level1); end
        m_lvl0 = 12;
        m_lvl1 = 12;
        m_inc += 2;
        drive(0, 0, IDLE_GAP);
    endtask
`endif

    task automatic test_pulse_exclusive();
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d want=0", both_cnt); end
        checks++; if (inc_cnt0 !== m_inc || dec_cnt0 !== m_dec) begin failures++; $display("FAIL total_pulses got=%0d/%0d want=%0d/%0d", inc_cnt0, dec_cnt0, m_inc, m_dec); end
    endtask

    initial begin
        test_reset();
        test_cw_saturate();
        test_ccw_bounds();
        test_debounce();
        test_partial_load();
        test_random();
`ifdef ROTARY_ACCEL_EN
        test_accel();
`endif
        test_pulse_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rotary_level_ctrl.md
Name: rotary_level_ctrl

Overview:
- Parametrised quadrature rotary-encoder front end that converts a detented encoder into a bounded level value.
- Used for volume and brightness style controls on the Gameboy board.
- Adds input synchronisation, per-channel debounce, configurable range and width, optional wrap, a direct load port, and detent pulses.
- Counts one step per full detent cycle, 00 -> ... -> 00.

Parameters:
- WIDTH, 4, width of the level register.
- MIN_LEVEL, 9, lowest legal level.
- MAX_LEVEL, 14, highest legal level; must satisfy MIN_LEVEL <= RESET_LEVEL <= MAX_LEVEL < 2^WIDTH.
- RESET_LEVEL, 13, level after reset.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a filtered channel changes; 0 bypasses the filter.
- WRAP, 0, 1 = stepping past a bound wraps to the opposite bound; 0 = saturate.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rotary_inc_a  input  1  encoder channel A, asynchronous raw pin.
- rotary_inc_b  input  1  encoder channel B, asynchronous raw pin.
- load  input  1  synchronous load strobe.
- load_level  input  WIDTH  value for load; clamped to [MIN_LEVEL, MAX_LEVEL].
- level  output  WIDTH  current level, registered.
- inc_pulse  output  1  one-cycle pulse, registered, on each accepted clockwise detent.
- dec_pulse  output  1  one-cycle pulse, registered, on each accepted counter-clockwise detent.
- at_min  output  1  level == MIN_LEVEL, combinational from register.
- at_max  output  1  level == MAX_LEVEL, combinational from register.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on port reset.
- While reset is asserted:
  - level = RESET_LEVEL; inc_pulse = dec_pulse = 0.
  - Synchroniser flops and filtered channels = 0; debounce counters = 0; FSM = S_IDLE.
  - Reset mid-rotation discards the partial detent; no pulse is generated.
- Synchroniser: two flops per channel.
- Debounce, per channel:
  - The counter clears whenever the synchronised value equals the filtered value.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the filtered value takes the synchronised value and the counter clears.
  - DEBOUNCE_CYCLES = 0: filtered value = synchronised value.
- FSM on filtered (a, b). States are S_IDLE, S_A, S_AB_A, S_BA, S_B, S_AB_B, S_AB.
  - S_IDLE: a -> S_A; else b -> S_B; else stay.
  - S_A: 00 -> S_IDLE; 10 -> stay; else -> S_AB_A.
  - S_AB_A: 10 -> S_A; 01 -> S_BA; 11 -> stay; 00 -> S_IDLE with dec.
  - S_BA: a=1 -> S_AB_A; 00 -> S_IDLE with dec; 01 -> stay.
  - S_B: 00 -> S_IDLE; 01 -> stay; else -> S_AB_B.
  - S_AB_B: 01 -> S_B; 10 -> S_AB; 11 -> stay; 00 -> S_IDLE with inc.
  - S_AB: b=1 -> S_AB_B; 00 -> S_IDLE with inc; 10 -> stay.
  - Any unencoded state -> S_IDLE, with no step.
- Level update, registered on the same edge as the FSM transition:
  - inc: level == MAX_LEVEL -> (WRAP ? MIN_LEVEL : hold); else level + step.
  - dec: level == MIN_LEVEL -> (WRAP ? MAX_LEVEL : hold); else level - step.
  - A non-wrapping result outside the bounds is clamped to the bound.
  - step = 1 unless the optional feature is enabled.
- Pulses:
  - inc_pulse / dec_pulse assert for exactly one cycle per completed detent.
  - They assert even when the level saturates and holds.
  - They never assert together.
- Load:
  - load has priority over a detent in the same cycle; the level takes the clamped load_level.
  - The FSM still advances, and the pulse for that detent still fires.
- Latency, raw pin edge to level change: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Arithmetic is performed at WIDTH+1 bits to avoid overflow before clamping.

Optional Feature:
- Macro: ROTARY_ACCEL_EN.
- When defined:
  - Adds parameters ACCEL_WINDOW (default 1_000_000 cycles) and ACCEL_STEP (default 2).
  - A saturating gap counter clears on every detent.
  - If a detent arrives with gap counter < ACCEL_WINDOW, step = ACCEL_STEP; otherwise 1.
  - The gap counter resets to its saturated value, so the first detent after reset steps by 1.
- When undefined: step is fixed at 1, and the gap counter logic is absent.

Test Plan:
- Reset with defaults -> level=13, at_min=0, at_max=0, no pulses; assert reset mid-sequence 10,11 -> level=13, FSM idle, no pulse after release.
- B-leading sequence 00,01,11,10,00, each held 10 cycles -> one inc_pulse, level 13->14, at_max=1; a second sequence -> inc_pulse, level holds 14.
- A-leading sequences x6 from 13 -> six dec_pulses, level 12,11,10,9,9,9, at_min=1; repeat with WRAP=1 from 9 -> level 14.
- Glitch on A lasting 3 cycles with DEBOUNCE_CYCLES=4 -> filtered A unchanged, no state change, level unchanged; 4-cycle hold -> accepted.
- Partial rotation 00,01,11,01,00 -> no pulse, level unchanged; load=1 with load_level=15 coincident with a completing dec detent -> level=14 (clamped), dec_pulse=1.
- With ROTARY_ACCEL_EN, ACCEL_WINDOW=100: two inc detents 50 cycles apart from level 9 -> 10 (first), then 12.
